// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard: shadow slot
// layout, forwarding-select encodings, FSM states and memory opcodes.
package hazard_pkg;

  // Slot destination field is sized for the widest register file supported.
  localparam int SLOT_AW = 8;

  localparam logic [3:0] OPC_LW = 4'b1000;
  localparam logic [3:0] OPC_SW = 4'b1001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dst;
    logic               wr_en;
    logic               is_load;
    logic               is_mem;
  } slot_t;

  // The EX producer is younger than the MEM producer, so it wins. A load in EX
  // cannot forward yet: the source reads the register file (stall or MEM->MEM).
  function automatic logic [1:0] fwd_pick(input logic ex_hit,
                                          input logic ex_load_hit,
                                          input logic mem_hit);
    if (ex_hit) return ex_load_hit ? FWD_RF : FWD_EX;
    if (mem_hit) return FWD_MEM;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one ID source operand against the EX and MEM shadow slots.
// hit_o = {ex_hit, ex_load_hit, mem_hit}.
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              id_valid_i,
  input  logic              src_used_i,
  input  logic [REG_AW-1:0] src_i,
  input  slot_t             ex_slot_i,
  input  slot_t             mem_slot_i,
  output logic [2:0]        hit_o
);

  logic               zero_src;
  logic               src_live;
  logic [SLOT_AW-1:0] src_ext;
  logic               ex_hit;
  logic               mem_hit;
  logic               ex_slot_mem_unused;
  logic               mem_slot_unused;

  assign src_ext  = SLOT_AW'(src_i);
  assign zero_src = (ZERO_REG != 0) && (src_i == '0);
  assign src_live = id_valid_i & src_used_i & ~zero_src;

  assign ex_hit  = src_live & ex_slot_i.valid & ex_slot_i.wr_en &
                   (ex_slot_i.dst == src_ext);
  assign mem_hit = src_live & mem_slot_i.valid & mem_slot_i.wr_en &
                   (mem_slot_i.dst == src_ext);

  assign hit_o = {ex_hit, ex_hit & ex_slot_i.is_load, mem_hit};

  // Memory-access kind of either slot does not affect operand matching.
  assign ex_slot_mem_unused = ex_slot_i.is_mem;
  assign mem_slot_unused    = mem_slot_i.is_load ^ mem_slot_i.is_mem;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage data-hazard unit: shadows EX/MEM destinations, issues load-use
// bubbles, freezes on a busy data memory and registers EX-aligned forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int               REG_AW   = 4,
  parameter int               NUM_SRC  = 2,
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] LW_OPC   = OPC_W'(OPC_LW),
  parameter logic [OPC_W-1:0] SW_OPC   = OPC_W'(OPC_SW),
  parameter int               ZERO_REG = 1,
  parameter int               CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [OPC_W-1:0]          id_opcode,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wr_en,
  input  logic                      mem_ready,
  input  logic                      flush,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      freeze,
  output logic [2*NUM_SRC-1:0]      fwd_sel_ex,
  output logic                      fwd_mm_ex,
  output logic [CNT_W-1:0]          stall_cycles,
  output hazard_state_e             dbg_state
);

  slot_t                  ex_q, ex_d, mem_q, mem_d, id_slot;
  logic [2*NUM_SRC-1:0]   fwd_sel_q, fwd_sel_d, fwd_sel_next;
  logic                   fwd_mm_q, fwd_mm_d, fwd_mm_next;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  hazard_state_e          state_q, state_d;

  logic [NUM_SRC-1:0][2:0] hits;
  logic [NUM_SRC-1:0]      load_use_src;
  logic                    load_use;
  logic                    is_store;
  logic                    mem_busy;
  logic                    stall_w;
  logic                    bubble_w;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_cmp #(
      .REG_AW  (REG_AW),
      .ZERO_REG(ZERO_REG)
    ) u_cmp (
      .id_valid_i(id_valid),
      .src_used_i(id_src_used[g]),
      .src_i     (id_src[g*REG_AW +: REG_AW]),
      .ex_slot_i (ex_q),
      .mem_slot_i(mem_q),
      .hit_o     (hits[g])
    );
  end

  assign is_store = id_valid & (id_opcode == SW_OPC);

  // The store-data source of a store can take a load result MEM->MEM,
  // so it is the one source that never stalls on a load in EX.
  always_comb begin
    load_use_src = '0;
    fwd_sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      load_use_src[i] = hits[i][1] & ~(is_store && (i == NUM_SRC - 1));
      fwd_sel_next[2*i +: 2] = fwd_pick(hits[i][2], hits[i][1], hits[i][0]);
    end
    fwd_mm_next = is_store & hits[NUM_SRC-1][1];
    load_use    = |load_use_src;
  end

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid;
    id_slot.dst     = SLOT_AW'(id_dst);
    id_slot.wr_en   = id_wr_en & ~((ZERO_REG != 0) && (id_dst == '0));
    id_slot.is_load = (id_opcode == LW_OPC);
    id_slot.is_mem  = (id_opcode == LW_OPC) | (id_opcode == SW_OPC);
  end

  // Freeze covers the entry cycle as well as the whole MEM_WAIT stay.
  assign mem_busy = mem_q.valid & mem_q.is_mem & ~mem_ready;
  assign stall_w  = mem_busy | (load_use & ~flush);
  assign bubble_w = load_use & ~flush & ~mem_busy;

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    fwd_sel_d = fwd_sel_q;
    fwd_mm_d  = fwd_mm_q;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (stall_w && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      RUN:      if (mem_busy) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase

    if (!mem_busy) begin
      mem_d = ex_q;
      if (bubble_w || flush) begin
        ex_d      = '0;
        fwd_sel_d = '0;
        fwd_mm_d  = 1'b0;
      end else begin
        ex_d      = id_slot;
        fwd_sel_d = fwd_sel_next;
        fwd_mm_d  = fwd_mm_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_sel_q <= '0;
      fwd_mm_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= RUN;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      fwd_sel_q <= fwd_sel_d;
      fwd_mm_q  <= fwd_mm_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign stall_id     = stall_w;
  assign bubble_ex    = bubble_w;
  assign freeze       = mem_busy;
  assign fwd_sel_ex   = fwd_sel_q;
  assign fwd_mm_ex    = fwd_mm_q;
  assign stall_cycles = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised data-hazard unit for the 5-stage pipeline; sits in ID and replaces purely combinational hazard detection.
- Keeps its own shadow copy of the EX and MEM stage destinations, so the ID/EX and EX/MEM register-write fields no longer need to be routed into it.
- Issues load-use bubbles and freezes the pipe while data memory is busy.
- Produces registered forwarding selects that are aligned to the instruction when it reaches EX, plus a saturating stall counter.

Parameters:
- REG_AW, 4: register-index width (2**REG_AW registers).
- NUM_SRC, 2: source operands per instruction. Index NUM_SRC-1 is the store-data source.
- OPC_W, 4: opcode width.
- LW_OPC, 4'b1000: load opcode.
- SW_OPC, 4'b1001: store opcode.
- ZERO_REG, 1: if 1, register 0 is hardwired; writes to it never create hazards.
- CNT_W, 16: stall-counter width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- id_valid, in, 1: ID holds a real instruction.
- id_opcode, in, OPC_W: ID opcode.
- id_src, in, NUM_SRC*REG_AW: source register indices; source i is at [i*REG_AW +: REG_AW].
- id_src_used, in, NUM_SRC: per-source "actually read" flag.
- id_dst, in, REG_AW: ID destination register.
- id_wr_en, in, 1: ID instruction writes the register file.
- mem_ready, in, 1: data memory completed or idle this cycle.
- flush, in, 1: branch flush; squashes the ID instruction.
- stall_id, out, 1: hold PC and IF/ID (combinational).
- bubble_ex, out, 1: load NOP into ID/EX (combinational).
- freeze, out, 1: hold all pipeline registers (combinational).
- fwd_sel_ex, out, 2*NUM_SRC: per-source select, registered. 00 = register file, 01 = EX->EX, 10 = MEM->EX.
- fwd_mm_ex, out, 1: MEM->MEM store-data forward, registered.
- stall_cycles, out, CNT_W: saturating count of stall_id cycles.

Behaviour:
- Shadow slots. EX slot and MEM slot each hold {valid, dst, wr_en, is_load, is_mem}.
  - ID is "writing" if id_valid & id_wr_en & ~(ZERO_REG & id_dst==0).
- Match. src_i matches a slot if:
  - id_valid & id_src_used[i] & slot.valid & slot.wr_en, and
  - slot.dst==src_i, and
  - src_i != 0 when ZERO_REG=1.
- Priority. An EX-slot match wins over a MEM-slot match, because it is the younger producer.
- Load-use. A source matching an EX-slot load is a load-use hazard, with one exception:
  - Exception: source NUM_SRC-1 of a store (id_opcode==SW_OPC) whose only EX match is a load.
  - That case sets fwd_mm_next=1 and does not stall.
- State machine, two states, reset to RUN:
  - RUN: freeze=0. stall_id = bubble_ex = load_use & ~flush.
  - RUN -> MEM_WAIT when MEM slot is_mem & valid & ~mem_ready.
  - While in MEM_WAIT: freeze=1 and stall_id=1; bubble_ex=0; slots, fwd regs and state are held.
  - MEM_WAIT -> RUN on the first cycle mem_ready=1. Slots advance on that cycle.
- Freeze is combinational and includes the entry cycle: freeze = MEM slot is_mem & valid & ~mem_ready.
- Slot update at posedge, evaluated in this order:
  1. rst: both slots invalid; fwd_sel_ex=0; fwd_mm_ex=0; stall_cycles=0; state=RUN.
  2. freeze: hold everything.
  3. bubble_ex: MEM<=EX; EX<=invalid; fwd regs<=0.
  4. flush: MEM<=EX; EX<=invalid; fwd regs<=0.
  5. Otherwise: MEM<=EX; EX<=ID fields (valid=id_valid); fwd_sel_ex<=fwd_sel_next; fwd_mm_ex<=fwd_mm_next.
- Forward select per source:
  - 01 on an EX match that is not a load.
  - 10 on a MEM match.
  - 00 otherwise, including when a load-use is pending.
- Load-use resolution. After the one bubble cycle the load sits in the MEM slot, so the re-evaluated ID instruction gets 10. Exactly one bubble per load-use.
- Latency. Hazard outputs are combinational on current ID/slot state. Forward selects appear one cycle after ID evaluation, aligned with EX.
- stall_cycles increments on every cycle stall_id=1 and saturates at all-ones. It is not cleared by flush.
- Simultaneous events:
  - freeze overrides bubble and flush. A flush asserted during MEM_WAIT is ignored by this block, and upstream must re-issue it.
  - flush with load_use gives no stall.
- Reset mid-MEM_WAIT returns to RUN with empty slots on the next edge.

Decomposition:
- Package hazard_pkg holds:
  - the slot_t struct {valid, dst, wr_en, is_load, is_mem};
  - the fwd_sel encodings FWD_RF/FWD_EX/FWD_MEM;
  - the state enum RUN/MEM_WAIT;
  - the opcode constants.
- One sub-module, hazard_src_cmp, instantiated NUM_SRC times via generate. It compares one source against both slots and returns {ex_hit, ex_load_hit, mem_hit}.

Test Plan:
- ADD r3 then SUB r4,r3,r1 back-to-back. Required: no stall; fwd_sel_ex=01 on src0 the cycle SUB is in EX.
- LW r5 then ADD r6,r5,r5. Required: stall_id=bubble_ex=1 for exactly 1 cycle; next cycle fwd_sel_ex=1010; stall_cycles=1.
- LW r5 then SW r5,0(r2), with store data on src1. Required: no stall; fwd_mm_ex=1; fwd_sel_ex src1=00.
- SW in MEM with mem_ready=0 for 3 cycles. Required: freeze=stall_id=1 for 3 cycles, fwd regs and slots held; advance on the 4th cycle; stall_cycles=3.
- ADD r0 followed by a reader of r0, with ZERO_REG=1. Required: fwd_sel_ex=00. Repeat with ZERO_REG=0. Required: 01.
- rst asserted during MEM_WAIT, and separately flush coincident with a load-use. Required: state RUN, all outputs 0 after reset; no bubble on flush.
- Also parametrically run NUM_SRC=3, REG_AW=5 with random traffic against a reference model.
